nonce_sweep_ctrl: RTL and testbench

//  Next-generation mining controller. Sweeps a programmable nonce range
//  [nonce_lo, nonce_hi] across N_CORES parallel hash cores, one batch at a time.
//  Per-core results are collected with a start/done handshake. Sweep stops on the

---
 rtl/mining_pkg.sv | 29 ++
 rtl/nonce_batch_gen.sv | 25 ++
 rtl/nonce_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// Shared definitions for the nonce sweep controller: state codes, widths, helpers.
package mining_pkg;

    localparam int unsigned NONCE_W_DEF = 32;
    localparam int unsigned MAX_CORES   = 16;
    localparam int unsigned CORE_IDX_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_ISSUE   = 3'b010,
        ST_WAIT    = 3'b011,
        ST_CHECK   = 3'b100,
        ST_FOUND   = 3'b101,
        ST_EXHAUST = 3'b110,
        ST_FAULT   = 3'b111
    } state_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [CORE_IDX_W-1:0] lowest_set(input logic [MAX_CORES-1:0] vec);
        logic [CORE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (vec[i]) idx = CORE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nonce_batch_gen.sv
// Per-core nonce and enable generation for one batch starting at base.
module nonce_batch_gen #(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned NONCE_W = 32
) (
    input  logic [NONCE_W-1:0]         base,
    input  logic [NONCE_W-1:0]         hi,
    output logic [N_CORES-1:0]         en_c,
    output logic [N_CORES*NONCE_W-1:0] nonce_c
);

    // A lane is enabled only if base+i neither wraps nor passes hi.
    always_comb begin
        logic [NONCE_W:0] sum;
        en_c    = '0;
        nonce_c = '0;
        sum     = '0;
        for (int i = 0; i < int'(N_CORES); i++) begin
            sum                           = {1'b0, base} + (NONCE_W+1)'(i);
            nonce_c[i*NONCE_W +: NONCE_W] = sum[NONCE_W-1:0];
            en_c[i]                       = !sum[NONCE_W] && (sum[NONCE_W-1:0] <= hi);
        end
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Batch-wise nonce range sweep across a hash-core array with hit/exhaust/abort/watchdog stop.
module nonce_sweep_ctrl
    import mining_pkg::*;
#(
    parameter int unsigned N_CORES = 4,
    parameter int unsigned NONCE_W = NONCE_W_DEF,
    parameter int unsigned WDOG_W  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NONCE_W-1:0]         nonce_lo,
    input  logic [NONCE_W-1:0]         nonce_hi,
    input  logic [N_CORES-1:0]         core_done,
    input  logic [N_CORES-1:0]         core_hit,
    output logic                       core_start,
    output logic [N_CORES-1:0]         core_en,
    output logic [N_CORES*NONCE_W-1:0] core_nonce,
    output logic [2:0]                 state,
    output logic                       busy,
    output logic                       found,
    output logic [NONCE_W-1:0]         found_nonce,
    output logic                       exhausted,
    output logic                       fault,
    output logic [NONCE_W-1:0]         batch_cnt
);

    localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

    state_e                     state_q, state_d;
    logic [NONCE_W-1:0]         base_q, base_d;
    logic [NONCE_W-1:0]         hi_q, hi_d;
    logic [NONCE_W-1:0]         batch_cnt_q, batch_cnt_d;
    logic [NONCE_W-1:0]         found_nonce_q, found_nonce_d;
    logic [WDOG_W-1:0]          wdog_q, wdog_d;
    logic [N_CORES-1:0]         core_en_q, core_en_d;
    logic [N_CORES*NONCE_W-1:0] core_nonce_q, core_nonce_d;
    logic                       core_start_q, core_start_d;
    logic                       busy_q, busy_d;
    logic                       found_q, found_d;
    logic                       exhausted_q, exhausted_d;
    logic                       fault_q, fault_d;

    logic [N_CORES-1:0]         gen_en_c;
    logic [N_CORES*NONCE_W-1:0] gen_nonce_c;
    logic [N_CORES-1:0]         hits_c;
    logic [NONCE_W:0]           next_base_c;

    nonce_batch_gen #(
        .N_CORES (N_CORES),
        .NONCE_W (NONCE_W)
    ) u_batch_gen (
        .base    (base_q),
        .hi      (hi_q),
        .en_c    (gen_en_c),
        .nonce_c (gen_nonce_c)
    );

    assign hits_c      = core_hit & core_en_q;
    assign next_base_c = {1'b0, base_q} + (NONCE_W+1)'(N_CORES);

    // Next-state, datapath and flag computation; abort overrides everything.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        hi_d          = hi_q;
        batch_cnt_d   = batch_cnt_q;
        found_nonce_d = found_nonce_q;
        wdog_d        = wdog_q;
        core_en_d     = core_en_q;
        core_nonce_d  = core_nonce_q;
        core_start_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUST, ST_FAULT: begin
                    if (start) begin
                        hi_d          = nonce_hi;
                        base_d        = nonce_lo;
                        batch_cnt_d   = '0;
                        found_nonce_d = '0;
                        state_d       = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (base_q > hi_q) begin
                        state_d = ST_EXHAUST;
                    end else begin
                        core_en_d    = gen_en_c;
                        core_nonce_d = gen_nonce_c;
                        state_d      = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    core_start_d = 1'b1;
                    batch_cnt_d  = batch_cnt_q + NONCE_W'(1);
                    wdog_d       = '0;
                    state_d      = ST_WAIT;
                end
                ST_WAIT: begin
                    // Stale done from the previous batch is still up while core_start is visible.
                    wdog_d = wdog_q + WDOG_W'(1);
                    if (!core_start_q && ((core_done & core_en_q) == core_en_q)) begin
                        state_d = ST_CHECK;
                    end else if (wdog_d == WDOG_MAX) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_CHECK: begin
                    if (hits_c != '0) begin
                        found_nonce_d = base_q + NONCE_W'(lowest_set(MAX_CORES'(hits_c)));
                        state_d       = ST_FOUND;
                    end else if (next_base_c[NONCE_W] || (next_base_c[NONCE_W-1:0] > hi_q)) begin
                        state_d = ST_EXHAUST;
                    end else begin
                        base_d  = next_base_c[NONCE_W-1:0];
                        state_d = ST_LOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d      = (state_d == ST_LOAD) || (state_d == ST_ISSUE) ||
                      (state_d == ST_WAIT) || (state_d == ST_CHECK);
        found_d     = (state_d == ST_FOUND);
        exhausted_d = (state_d == ST_EXHAUST);
        fault_d     = (state_d == ST_FAULT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            hi_q          <= '0;
            batch_cnt_q   <= '0;
            found_nonce_q <= '0;
            wdog_q        <= '0;
            core_en_q     <= '0;
            core_nonce_q  <= '0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            hi_q          <= hi_d;
            batch_cnt_q   <= batch_cnt_d;
            found_nonce_q <= found_nonce_d;
            wdog_q        <= wdog_d;
            core_en_q     <= core_en_d;
            core_nonce_q  <= core_nonce_d;
            core_start_q  <= core_start_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            fault_q       <= fault_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_en     = core_en_q;
    assign core_nonce  = core_nonce_q;
    assign state       = state_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign exhausted   = exhausted_q;
    assign fault       = fault_q;
    assign batch_cnt   = batch_cnt_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Scoreboard bench for nonce_sweep_ctrl with a behavioural core array and sweep model.
module tb_nonce_sweep_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned NW = 32;
    localparam int unsigned WW = 4;

    typedef struct {
        logic [NC-1:0] en;
        logic [NW-1:0] base;
    } batch_t;

    typedef struct {
        logic [2:0]    st;
        logic [NW-1:0] fn;
        logic [NW-1:0] bc;
    } term_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [NW-1:0]     nonce_lo;
    logic [NW-1:0]     nonce_hi;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_hit;
    logic              core_start;
    logic [NC-1:0]     core_en;
    logic [NC*NW-1:0]  core_nonce;
    logic [2:0]        state;
    logic              busy;
    logic              found;
    logic [NW-1:0]     found_nonce;
    logic              exhausted;
    logic              fault;
    logic [NW-1:0]     batch_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int term_count = 0;
    int last_start_cyc = 0;
    int term_cyc = 0;
    int done_dly = 5;
    bit hang = 1'b0;
    int sweep_id = 0;
    logic [NC-1:0] hit_plan [64];

    batch_t exp_batches[$];
    term_t  exp_terms[$];

    always #5 clock = ~clock;

    nonce_sweep_ctrl #(
        .N_CORES (NC),
        .NONCE_W (NW),
        .WDOG_W  (WW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_lo    (nonce_lo),
        .nonce_hi    (nonce_hi),
        .core_done   (core_done),
        .core_hit    (core_hit),
        .core_start  (core_start),
        .core_en     (core_en),
        .core_nonce  (core_nonce),
        .state       (state),
        .busy        (busy),
        .found       (found),
        .found_nonce (found_nonce),
        .exhausted   (exhausted),
        .fault       (fault),
        .batch_cnt   (batch_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference sweep: walks the range in steps of NC with plain wide arithmetic.
    task automatic model(input logic [NW-1:0] lo, input logic [NW-1:0] hi);
        longint unsigned base;
        int              n;
        batch_t          b;
        term_t           t;
        logic [NC-1:0]   hits;
        base = 64'(lo);
        n    = 0;
        t.st = 3'd6;
        t.fn = '0;
        while (64'(lo) <= 64'(hi)) begin
            b.base = base[NW-1:0];
            b.en   = '0;
            for (int i = 0; i < int'(NC); i++)
                if (base + 64'(i) <= 64'(hi)) b.en[i] = 1'b1;
            exp_batches.push_back(b);
            hits = hit_plan[n & 63] & b.en;
            n++;
            if (hits != '0) begin
                int idx;
                idx = -1;
                for (int i = 0; i < int'(NC); i++)
                    if (hits[i] && idx < 0) idx = i;
                t.st = 3'd5;
                t.fn = NW'(base + 64'(idx));
                break;
            end
            if (base + 64'(NC) > 64'(hi)) break;
            base = base + 64'(NC);
        end
        t.bc = NW'(n);
        exp_terms.push_back(t);
    endtask

    // Monitor: pops expected batches on core_start and expected outcomes when busy drops.
    batch_t mb;
    term_t  mt;
    bit     prev_busy = 1'b0;
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (core_start) begin
                last_start_cyc = cyc;
                if (exp_batches.size() == 0) begin
                    check("unexpected_core_start", 64'd1, 64'd0);
                end else begin
                    mb = exp_batches.pop_front();
                    check("core_en", 64'(core_en), 64'(mb.en));
                    for (int i = 0; i < int'(NC); i++)
                        if (mb.en[i]) check("core_nonce", 64'(core_nonce[i*NW +: NW]), 64'(mb.base + NW'(i)));
                end
            end
            if (prev_busy && !busy) begin
                term_cyc = cyc;
                term_count++;
                if (exp_terms.size() == 0) begin
                    check("unexpected_terminal", 64'd1, 64'd0);
                end else begin
                    mt = exp_terms.pop_front();
                    check("state", 64'(state), 64'(mt.st));
                    check("found", 64'(found), 64'(mt.st == 3'd5));
                    check("exhausted", 64'(exhausted), 64'(mt.st == 3'd6));
                    check("fault", 64'(fault), 64'(mt.st == 3'd7));
                    check("batch_cnt", 64'(batch_cnt), 64'(mt.bc));
                    if (mt.st == 3'd5) check("found_nonce", 64'(found_nonce), 64'(mt.fn));
                    check("batches_left", 64'(exp_batches.size()), 64'd0);
                end
            end
            prev_busy = busy;
        end
    end

    // Hash-core array model: done (and hit) some cycles after each core_start, sticky until the next.
    bit start_seen = 1'b0;
    always @(negedge clock) if (core_start) start_seen = 1'b1;

    int cd = 0;
    int cur_batch = 0;
    int core_batch = 0;
    int seen_id = 0;
    always @(posedge clock) begin
        #1;
        if (reset) begin
            core_done = '0;
            core_hit  = '0;
            cd        = 0;
        end else begin
            if (seen_id != sweep_id) begin
                seen_id    = sweep_id;
                core_batch = 0;
            end
            if (start_seen) begin
                start_seen = 1'b0;
                core_done  = '0;
                core_hit   = '0;
                cd         = done_dly;
                cur_batch  = core_batch;
                core_batch++;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && !hang) begin
                    core_done = core_en;
                    core_hit  = hit_plan[cur_batch & 63];
                end
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 64; i++) hit_plan[i] = '0;
    endtask

    task automatic pulse_start(input logic [NW-1:0] lo, input logic [NW-1:0] hi);
        sweep_id++;
        @(posedge clock); #1;
        nonce_lo = lo;
        nonce_hi = hi;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        nonce_lo = $urandom;
        nonce_hi = $urandom;
    endtask

    task automatic wait_term(input int tc0, input bit poke);
        int n;
        n = 0;
        while (term_count == tc0 && n < 2000) begin
            @(posedge clock); #1;
            n++;
            start = (poke && n == 4);
            if (poke && n == 4) nonce_lo = 32'hDEAD_0000;
        end
        start = 1'b0;
        if (term_count == tc0) check("sweep_timeout", 64'd1, 64'd0);
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic run_sweep(input logic [NW-1:0] lo, input logic [NW-1:0] hi, input bit poke);
        int tc0;
        model(lo, hi);
        tc0 = term_count;
        pulse_start(lo, hi);
        wait_term(tc0, poke);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [NW-1:0] lo, hi;
        int            len, tc0, n;
        batch_t        b;
        term_t         t;

        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        nonce_lo = '0;
        nonce_hi = '0;
        clear_plan();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", 64'(state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", 64'({found, exhausted, fault}), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_core_en", 64'(core_en), 64'd0);
        check("rst_batch_cnt", 64'(batch_cnt), 64'd0);
        check("rst_found_nonce", 64'(found_nonce), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Full exhaustion over three batches.
        done_dly = 5;
        run_sweep(32'd0, 32'd11, 1'b0);

        // Hit on core 2 in the second batch, with a start pulse while busy.
        clear_plan();
        hit_plan[1] = 4'b0100;
        run_sweep(32'h100, 32'h1FF, 1'b1);

        // Two hits in a batch: lowest index wins.
        clear_plan();
        hit_plan[1] = 4'b1010;
        run_sweep(32'h100, 32'h1FF, 1'b0);

        // Top of the nonce space: partial batch, no wrap; hits on disabled lanes ignored.
        clear_plan();
        hit_plan[0] = 4'b1100;
        run_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);

        // Empty range.
        clear_plan();
        run_sweep(32'h20, 32'h1F, 1'b0);

        // Randomised sweeps.
        for (int k = 0; k < 14; k++) begin
            clear_plan();
            done_dly = int'($urandom_range(1, 8));
            lo = $urandom;
            if ($urandom_range(0, 2) == 0) lo = 32'hFFFF_FFF0 + NW'($urandom_range(0, 15));
            len = int'($urandom_range(0, 20));
            if (64'(lo) + 64'(len) > 64'h0000_0000_FFFF_FFFF) hi = 32'hFFFF_FFFF;
            else hi = lo + NW'(len);
            if ($urandom_range(0, 7) == 0 && lo != '0) hi = lo - 1;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 3) == 0) hit_plan[i] = NC'($urandom);
            run_sweep(lo, hi, 1'b0);
        end

        // Abort with a simultaneous start while waiting on the cores.
        clear_plan();
        done_dly = 8;
        b.base = 32'h50;
        b.en   = 4'b1111;
        exp_batches.push_back(b);
        t.st = 3'd0; t.fn = '0; t.bc = 32'd1;
        exp_terms.push_back(t);
        tc0 = last_start_cyc;
        pulse_start(32'h50, 32'h60);
        n = 0;
        while (last_start_cyc == tc0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (last_start_cyc == tc0) check("abort_no_start_seen", 64'd1, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        abort    = 1'b1;
        start    = 1'b1;
        nonce_lo = 32'h7000;
        nonce_hi = 32'h8000;
        @(posedge clock); #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("abort_state", 64'(state), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_found", 64'(found), 64'd0);
        check("abort_core_start", 64'(core_start), 64'd0);
        repeat (15) @(posedge clock);
        #1;

        // Cores never answer: watchdog fault, then a clean restart from nonce_lo.
        clear_plan();
        done_dly = 3;
        hang = 1'b1;
        lo = $urandom & 32'h7FFF_FFFF;
        b.base = lo;
        b.en   = 4'b1111;
        exp_batches.push_back(b);
        t.st = 3'd7; t.fn = '0; t.bc = 32'd1;
        exp_terms.push_back(t);
        tc0 = term_count;
        pulse_start(lo, lo + 32'd7);
        wait_term(tc0, 1'b0);
        check("wdog_latency", 64'(term_cyc - last_start_cyc), 64'd15);
        hang = 1'b0;
        lo = $urandom & 32'h7FFF_FFFF;
        hit_plan[1] = 4'b0001;
        run_sweep(lo, lo + 32'd9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
